// File: rtl/debounce_pkg.sv
// Shared definitions for the switch-bounce emulator and its debouncer:
// state codes, LFSR defaults/taps and the bounce phase width.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BOUNCE = 2'b01,
        ST_SETTLE = 2'b10
    } bounce_state_t;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Fibonacci tap positions, numbered 1..16 from the output end.
    localparam int LFSR_TAP_A = 16;
    localparam int LFSR_TAP_B = 14;
    localparam int LFSR_TAP_C = 13;
    localparam int LFSR_TAP_D = 11;

    localparam int PHASE_W  = 8;
    localparam int TOGGLE_W = 5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        logic fb;
        fb = q[16-LFSR_TAP_A] ^ q[16-LFSR_TAP_B] ^ q[16-LFSR_TAP_C] ^ q[16-LFSR_TAP_D];
        return {fb, q[15:1]};
    endfunction

    // Two toggles per glitch pair, plus one more if the line must change level.
    function automatic logic [TOGGLE_W-1:0] toggle_count(input logic [3:0] n_pairs,
                                                         input logic       target,
                                                         input logic       current);
        return {n_pairs, 1'b0} + {4'b0000, target ^ current};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; supplies pseudo-random bounce phase widths.
module lfsr16
    import debounce_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // A zero seed would lock the register at zero forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/bounce_gen.sv
// Emulates a bouncing mechanical switch: a burst of randomly spaced toggles
// on sw_out, then a long stable hold at the requested level.
module bounce_gen
    import debounce_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 3000000,
    parameter logic        RESET_LEVEL = 1'b0,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       level_in,
    input  logic [3:0] n_bounce,
    output logic       sw_out,
    output logic       busy,
    output logic       done
);

    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    bounce_state_t       r_state;
    bounce_state_t       w_state_nxt;
    logic                r_sw;
    logic                w_sw_nxt;
    logic                r_target;
    logic                w_target_nxt;
    logic [TOGGLE_W-1:0] r_rem;
    logic [TOGGLE_W-1:0] w_rem_nxt;
    logic [PHASE_W-1:0]  r_interval;
    logic [PHASE_W-1:0]  w_interval_nxt;
    logic [SETTLE_W-1:0] r_settle;
    logic [SETTLE_W-1:0] w_settle_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic [TOGGLE_W-1:0] w_toggles;
    logic [15:0]         w_lfsr;
    logic                w_unused_lfsr_hi;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (w_lfsr)
    );

    assign w_unused_lfsr_hi = ^w_lfsr[15:PHASE_W];
    assign w_toggles        = toggle_count(n_bounce, level_in, r_sw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sw       <= RESET_LEVEL;
            r_target   <= RESET_LEVEL;
            r_rem      <= '0;
            r_interval <= '0;
            r_settle   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sw       <= w_sw_nxt;
            r_target   <= w_target_nxt;
            r_rem      <= w_rem_nxt;
            r_interval <= w_interval_nxt;
            r_settle   <= w_settle_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sw_nxt       = r_sw;
        w_target_nxt   = r_target;
        w_rem_nxt      = r_rem;
        w_interval_nxt = r_interval;
        w_settle_nxt   = r_settle;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_target_nxt = level_in;
                    if (w_toggles != '0) begin
                        w_sw_nxt       = ~r_sw;
                        w_rem_nxt      = w_toggles - 5'd1;
                        w_interval_nxt = w_lfsr[PHASE_W-1:0];
                        w_state_nxt    = ST_BOUNCE;
                    end else begin
                        w_settle_nxt = SETTLE_LOAD;
                        w_state_nxt  = ST_SETTLE;
                    end
                end
            end

            ST_BOUNCE: begin
                if (r_interval != '0) begin
                    w_interval_nxt = r_interval - 8'd1;
                end else if (r_rem != '0) begin
                    w_sw_nxt       = ~r_sw;
                    w_rem_nxt      = r_rem - 5'd1;
                    w_interval_nxt = w_lfsr[PHASE_W-1:0];
                end else begin
                    w_settle_nxt = SETTLE_LOAD;
                    w_state_nxt  = ST_SETTLE;
                end
            end

            // The toggle count parity guarantees sw_out already equals the target here.
            ST_SETTLE: begin
                w_sw_nxt = r_target;
                if (r_settle != '0) begin
                    w_settle_nxt = r_settle - SETTLE_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sw_out = r_sw;
    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: directed scenarios plus random sequences
// against an event-schedule reference model.
`timescale 1ns/1ps
module tb_bounce_gen;

    localparam int          SETTLE = 16;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       level_in = 1'b0;
    logic [3:0] n_bounce = 4'd0;
    logic       sw_out;
    logic       busy;
    logic       done;

    bounce_gen #(
        .SETTLE_CYC  (SETTLE),
        .RESET_LEVEL (1'b0),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .level_in (level_in),
        .n_bounce (n_bounce),
        .sw_out   (sw_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: LFSR value before the next edge, output levels, and a
    // schedule of absolute edge numbers at which sw_out toggles / done fires.
    logic [15:0] mLfsr = SEED;
    logic        mSw = 1'b0;
    logic        mBusy = 1'b0;
    logic        mDone = 1'b0;
    logic        expTarget = 1'b0;
    int          toggleQ[$];
    int          doneEdge = 0;
    int          edgeN = 0;
    int          mToggled = 0;
    int          expTrans = 0;

    // Observations of the DUT for the current sequence.
    logic prevSw = 1'b0;
    int   obsTrans = 0;
    int   lastTransEdge = -1;
    int   gapBad = 0;
    int   doneCnt = 0;
    int   doneObsEdge = 0;
    int   acceptEdge = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (edge %0d)", tag, observed, expected, edgeN);
        end
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [15:0] lfsrAfter(input logic [15:0] v, input int n);
        logic [15:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = lfsrStep(x);
        return x;
    endfunction

    task automatic modelEdge();
        logic [15:0] v;
        logic [15:0] w;
        int          t;
        int          nT;
        v     = mLfsr;
        mDone = 1'b0;
        if (mBusy) begin
            if (edgeN == doneEdge) begin
                mBusy = 1'b0;
                mDone = 1'b1;
            end
        end else if (start) begin
            nT = 2 * int'(n_bounce) + ((level_in != mSw) ? 1 : 0);
            t  = edgeN;
            for (int i = 0; i < nT; i++) begin
                toggleQ.push_back(t);
                w = lfsrAfter(v, t - edgeN);
                t = t + int'(w[7:0]) + 1;
            end
            doneEdge      = t + SETTLE;
            mBusy         = 1'b1;
            expTarget     = level_in;
            expTrans      = nT;
            acceptEdge    = edgeN;
            obsTrans      = 0;
            lastTransEdge = -1;
            gapBad        = 0;
            doneCnt       = 0;
        end
        if (toggleQ.size() > 0 && toggleQ[0] == edgeN) begin
            mSw = ~mSw;
            void'(toggleQ.pop_front());
            mToggled++;
        end
        mLfsr = lfsrStep(mLfsr);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("sw_out", sw_out, mSw);
        checkOutput("busy", busy, mBusy);
        checkOutput("done", done, mDone);
        checkOutput("lfsr", dut.w_lfsr, mLfsr);
        if (sw_out !== prevSw) begin
            obsTrans++;
            if (lastTransEdge >= 0 && (edgeN - lastTransEdge) > 256) gapBad++;
            lastTransEdge = edgeN;
        end
        if (done === 1'b1) begin
            doneCnt++;
            doneObsEdge = edgeN;
        end
        prevSw = sw_out;
        edgeN++;
    endtask

    task automatic applyStimulus(input logic s, input logic lvl, input logic [3:0] n);
        start    = s;
        level_in = lvl;
        n_bounce = n;
        tick();
        start    = 1'b0;
    endtask

    task automatic runToIdle();
        int c;
        c = 0;
        while ((mBusy || busy === 1'b1) && c < 12000) begin
            tick();
            c++;
        end
        checkOutput("idle_timeout", busy, 0);
    endtask

    task automatic sequenceChecks();
        checkOutput("transitions", obsTrans, expTrans);
        checkOutput("gap_range", gapBad, 0);
        checkOutput("done_pulses", doneCnt, 1);
        checkOutput("final_level", sw_out, expTarget);
        if (expTrans == 0)
            checkOutput("done_latency", doneObsEdge - acceptEdge, SETTLE);
        else
            checkOutput("settle_hold", ((doneObsEdge - lastTransEdge) >= SETTLE) ? 1 : 0, 1);
    endtask

    task automatic asyncReset();
        rst_n = 1'b0;
        #1;
        mSw   = 1'b0;
        mBusy = 1'b0;
        mDone = 1'b0;
        mLfsr = SEED;
        toggleQ.delete();
        checkOutput("rst_sw", sw_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_lfsr", dut.w_lfsr, SEED);
        prevSw = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_hold_lfsr", dut.w_lfsr, SEED);
        checkOutput("rst_hold_sw", sw_out, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int          base;
        int          c;
        int          gapN;
        logic        lvl;
        logic [3:0]  nb;

        #2;
        asyncReset();

        // Idle after reset: LFSR free-runs, outputs quiet.
        repeat (3) tick();

        // Single toggle to 1, then settle.
        applyStimulus(1'b1, 1'b1, 4'd0);
        runToIdle();
        sequenceChecks();

        // Already at target: no transitions, done after the settle time.
        applyStimulus(1'b1, 1'b1, 4'd0);
        runToIdle();
        sequenceChecks();

        // Back to 0, then 0 -> 1 with two glitch pairs (five transitions).
        applyStimulus(1'b1, 1'b0, 4'd0);
        runToIdle();
        sequenceChecks();
        applyStimulus(1'b1, 1'b1, 4'd2);
        runToIdle();
        sequenceChecks();

        // A second start during the bounce burst must be ignored.
        applyStimulus(1'b1, 1'b0, 4'd3);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b1, 4'd5);
        runToIdle();
        sequenceChecks();

        // Reset during the third bounce phase abandons the sequence.
        base = mToggled;
        applyStimulus(1'b1, 1'b1, 4'd4);
        c = 0;
        while (mToggled < base + 3 && c < 3000) begin
            tick();
            c++;
        end
        checkOutput("third_phase_transitions", obsTrans, 3);
        asyncReset();
        repeat (SETTLE + 4) tick();
        checkOutput("abort_no_done", doneCnt, 0);

        applyStimulus(1'b1, 1'b1, 4'd1);
        runToIdle();
        sequenceChecks();

        // Random sequences, some back-to-back with done and some with stray starts.
        for (int k = 0; k < 12; k++) begin
            gapN = int'($urandom_range(0, 2));
            repeat (gapN) tick();
            lvl = 1'($urandom_range(0, 1));
            nb  = 4'($urandom_range(0, 15));
            applyStimulus(1'b1, lvl, nb);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) tick();
                if (mBusy) applyStimulus(1'b1, ~lvl, 4'($urandom_range(0, 15)));
            end
            runToIdle();
            sequenceChecks();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
